// File: rtl/anton_neopixel_frame_ctrl_pkg.sv
// Package for the NeoPixel frame controller: the two-state FSM type, encoded
// with the shared state values so the registered state can be handed
// straight to the stream controller.
`include "anton_common.vh"

package anton_neopixel_frame_ctrl_pkg;

  typedef enum logic {
    ST_TRANSMIT = `ENUM_STATE_TRANSMIT,
    ST_RESET    = `ENUM_STATE_RESET
  } state_e;

endpackage

// File: rtl/anton_common.vh
// Shared definitions for the anton NeoPixel blocks: FSM state encodings seen
// by the stream controller, default buffer size and a constant-expression
// ceil(log2) usable in parameter and port declarations.
`ifndef ANTON_COMMON_VH
`define ANTON_COMMON_VH

`define ENUM_STATE_TRANSMIT 1'b0
`define ENUM_STATE_RESET    1'b1

`define BUFFER_END_DEFAULT 255

// Constant ceil(log2(x)) for x up to 2**16; evaluates at elaboration time.
`define CLOG2(x) \
  ((x) <= 1     ? 0  : (x) <= 2     ? 1  : (x) <= 4     ? 2  : (x) <= 8     ? 3  : \
   (x) <= 16    ? 4  : (x) <= 32    ? 5  : (x) <= 64    ? 6  : (x) <= 128   ? 7  : \
   (x) <= 256   ? 8  : (x) <= 512   ? 9  : (x) <= 1024  ? 10 : (x) <= 2048  ? 11 : \
   (x) <= 4096  ? 12 : (x) <= 8192  ? 13 : (x) <= 16384 ? 14 : (x) <= 32768 ? 15 : \
   (x) <= 65536 ? 16 : 32)

`endif

// File: rtl/anton_neopixel_gap_counter.sv
// Reset-gap (latch) counter for the NeoPixel frame controller.
// Counts enabled cycles; 'done' is high combinationally on the enabled cycle
// that completes RESET_CYCLES counts, and the count wraps to 0 on that edge.
// Ports:
//   clk7mhz - clock, rising edge
//   rst     - asynchronous active-high reset, count -> 0
//   clear   - synchronous clear, wins over enable
//   enable  - count this cycle
//   done    - last cycle of the gap (enable && count == RESET_CYCLES-1)
`include "anton_common.vh"

module anton_neopixel_gap_counter #(
  parameter int RESET_CYCLES = 420,
  parameter int COUNT_BITS   = `CLOG2(RESET_CYCLES)
) (
  input  logic clk7mhz,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  // A one-cycle gap needs no count bits, but the register still needs one.
  localparam int CW = (COUNT_BITS < 1) ? 1 : COUNT_BITS;
  localparam logic [CW-1:0] LAST = CW'(RESET_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  assign done = enable && !clear && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = done ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk7mhz or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/anton_neopixel_frame_ctrl.sv
// NeoPixel frame controller. Walks pixel_index through the frame one pixel
// per stream_bit_of pulse, then holds the line in a RESET gap of
// RESET_CYCLES active cycles before the next frame. Single-shot mode asks the
// register block to clear run at the end of the gap.
// Ports:
//   clk7mhz, rst            - clock, asynchronous active-high reset
//   reg_ctrl_init           - synchronous soft init (highest priority)
//   reg_ctrl_run            - streaming enabled
//   reg_ctrl_loop           - 1 = repeat frames, 0 = single frame
//   stream_bit_of           - end of current pixel (pulse)
//   pixel_index_max         - last pixel of the frame
//   state                   - registered FSM state for the stream controller
//   pixel_index             - pixel being transmitted / buffer read address
//   frame_done, run_clear   - one-cycle registered pulses at end of gap
`include "anton_common.vh"

module anton_neopixel_frame_ctrl
  import anton_neopixel_frame_ctrl_pkg::*;
#(
  parameter  int BUFFER_END   = `BUFFER_END_DEFAULT,
  parameter  int RESET_CYCLES = 420,
  localparam int BUFFER_BITS  = `CLOG2(BUFFER_END + 1),
  localparam int RESET_BITS   = `CLOG2(RESET_CYCLES)
) (
  input  logic                   clk7mhz,
  input  logic                   rst,
  input  logic                   reg_ctrl_init,
  input  logic                   reg_ctrl_run,
  input  logic                   reg_ctrl_loop,
  input  logic                   stream_bit_of,
  input  logic [BUFFER_BITS-1:0] pixel_index_max,
  output logic                   state,
  output logic [BUFFER_BITS-1:0] pixel_index,
  output logic                   frame_done,
  output logic                   run_clear
);

  localparam logic [BUFFER_BITS-1:0] BUF_LAST = BUFFER_BITS'(BUFFER_END);

  state_e                 state_q, state_d;
  logic [BUFFER_BITS-1:0] pixel_index_q, pixel_index_d;
  logic                   frame_done_q, frame_done_d;
  logic                   run_clear_q, run_clear_d;
  logic [BUFFER_BITS-1:0] eff_max;
  logic                   gap_clear, gap_enable, gap_done;

  // Clamp so a stale or oversized max never walks past the buffer.
  assign eff_max    = (pixel_index_max < BUF_LAST) ? pixel_index_max : BUF_LAST;
  assign gap_enable = reg_ctrl_run && !reg_ctrl_init && (state_q == ST_RESET);

  anton_neopixel_gap_counter #(
    .RESET_CYCLES (RESET_CYCLES),
    .COUNT_BITS   (RESET_BITS)
  ) u_gap (
    .clk7mhz (clk7mhz),
    .rst     (rst),
    .clear   (gap_clear),
    .enable  (gap_enable),
    .done    (gap_done)
  );

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path
    // leaves it unassigned, which would infer a latch.
    state_d       = state_q;
    pixel_index_d = pixel_index_q;
    frame_done_d  = 1'b0;
    run_clear_d   = 1'b0;
    gap_clear     = 1'b0;

    if (reg_ctrl_init) begin
      state_d       = ST_RESET;
      pixel_index_d = '0;
      gap_clear     = 1'b1;
    end else if (reg_ctrl_run) begin
      unique case (state_q)
        ST_TRANSMIT: begin
          if (stream_bit_of) begin
            // >= (not ==) so lowering max below the current pixel still ends the frame.
            if (pixel_index_q < eff_max) begin
              pixel_index_d = pixel_index_q + 1'b1;
            end else begin
              pixel_index_d = '0;
              state_d       = ST_RESET;
              gap_clear     = 1'b1;
            end
          end
        end
        ST_RESET: begin
          if (gap_done) begin
            state_d      = ST_TRANSMIT;
            frame_done_d = 1'b1;
            run_clear_d  = !reg_ctrl_loop;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk7mhz or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RESET;
      pixel_index_q <= '0;
      frame_done_q  <= 1'b0;
      run_clear_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      run_clear_q   <= run_clear_d;
    end
  end

  assign state       = state_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = frame_done_q;
  assign run_clear   = run_clear_q;

endmodule

// File: tb/tb_anton_neopixel_frame_ctrl.sv
// Bench for anton_neopixel_frame_ctrl. dut0 uses BUFFER_END=3 (2-bit index,
// so a max of 7 truncates to 3); dut1 uses BUFFER_END=4 with a 3-bit index so
// a max of 7 really exercises the clamp. Both share all other inputs.
module tb_anton_neopixel_frame_ctrl;
  import anton_neopixel_frame_ctrl_pkg::*;

  localparam int RC = 8;

  logic       clk7mhz = 1'b0;
  logic       rst, init, run, loop_en, bit_of;
  logic [2:0] max3;
  logic       st0, fd0, rc0, st1, fd1, rc1;
  logic [1:0] pix0;
  logic [2:0] pix1;

  int errors = 0;
  int checks = 0;

  // Reference model: per instance, "in gap", pixel, gap count, pulses.
  bit m_inrst[2];
  int m_pix[2];
  int m_gap[2];
  bit m_fd[2];
  bit m_rc[2];

  always #5 clk7mhz = ~clk7mhz;

  anton_neopixel_frame_ctrl #(.BUFFER_END(3), .RESET_CYCLES(RC)) dut0 (
    .clk7mhz(clk7mhz), .rst(rst), .reg_ctrl_init(init), .reg_ctrl_run(run),
    .reg_ctrl_loop(loop_en), .stream_bit_of(bit_of), .pixel_index_max(max3[1:0]),
    .state(st0), .pixel_index(pix0), .frame_done(fd0), .run_clear(rc0));

  anton_neopixel_frame_ctrl #(.BUFFER_END(4), .RESET_CYCLES(RC)) dut1 (
    .clk7mhz(clk7mhz), .rst(rst), .reg_ctrl_init(init), .reg_ctrl_run(run),
    .reg_ctrl_loop(loop_en), .stream_bit_of(bit_of), .pixel_index_max(max3),
    .state(st1), .pixel_index(pix1), .frame_done(fd1), .run_clear(rc1));

  function automatic logic exp_st(int k);
    return m_inrst[k] ? ST_RESET : ST_TRANSMIT;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_inrst[k] = 1'b1; m_pix[k] = 0; m_gap[k] = 0; m_fd[k] = 1'b0; m_rc[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int mx, eff, be;
      be  = (k == 0) ? 3 : 4;
      mx  = (k == 0) ? int'(max3[1:0]) : int'(max3);
      eff = (mx < be) ? mx : be;
      m_fd[k] = 1'b0;
      m_rc[k] = 1'b0;
      if (init) begin
        m_inrst[k] = 1'b1; m_pix[k] = 0; m_gap[k] = 0;
      end else if (run) begin
        if (!m_inrst[k]) begin
          if (bit_of) begin
            if (m_pix[k] < eff) m_pix[k]++;
            else begin m_pix[k] = 0; m_inrst[k] = 1'b1; m_gap[k] = 0; end
          end
        end else if (m_gap[k] == RC - 1) begin
          m_inrst[k] = 1'b0; m_gap[k] = 0; m_fd[k] = 1'b1; m_rc[k] = !loop_en;
        end else begin
          m_gap[k]++;
        end
      end
    end
  endtask

  // One clock: advance model at the edge, then settle past the edge.
  task automatic tick();
    @(posedge clk7mhz);
    if (!rst) model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b0; run = 1'b1; loop_en = 1'b1; bit_of = 1'b0; max3 = 3'd3;
    model_reset();
    #12;
    checks++; if (st0 !== ST_RESET) begin errors++; $display("FAIL reset_state: got %b expected %b", st0, ST_RESET); end
    checks++; if (pix0 !== 2'd0) begin errors++; $display("FAIL reset_pix: got %0d expected 0", pix0); end
    checks++; if (fd0 !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", fd0); end
    checks++; if (rc0 !== 1'b0) begin errors++; $display("FAIL reset_run_clear: got %b expected 0", rc0); end
    @(posedge clk7mhz); #1;
    rst = 1'b0;
  endtask

  task automatic test_first_gap();
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(); n++;
      if (fd0 === 1'b1) seen = 1;
    end
    checks++; if (!seen || n != RC) begin errors++; $display("FAIL first_gap_len: got %0d cycles (seen=%0d) expected %0d", n, seen, RC); end
    checks++; if (st0 !== ST_TRANSMIT) begin errors++; $display("FAIL first_gap_state: got %b expected %b", st0, ST_TRANSMIT); end
    checks++; if (pix0 !== 2'd0) begin errors++; $display("FAIL first_gap_pix: got %0d expected 0", pix0); end
  endtask

  task automatic test_pixels();
    bit_of = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pix0 !== 2'((i + 1) % 4)) begin errors++; $display("FAIL pixel_step%0d: got %0d expected %0d", i, pix0, (i + 1) % 4); end
      if (i == 0) begin
        checks++; if (fd0 !== 1'b0) begin errors++; $display("FAIL frame_done_width: got %b expected 0", fd0); end
      end
    end
    bit_of = 1'b0;
    checks++; if (st0 !== ST_RESET) begin errors++; $display("FAIL pixel_wrap_state: got %b expected %b", st0, ST_RESET); end
  endtask

  task automatic test_run_clear();
    int n_rc = 0, n_fd = 0, n_co = 0;
    loop_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rc0 === 1'b1) n_rc++;
      if (fd0 === 1'b1) n_fd++;
      if (rc0 === 1'b1 && fd0 === 1'b1) n_co++;
      if (rc0 === 1'b1) run = 1'b0;  // register block clears run
    end
    checks++; if (n_rc != 1 || n_co != 1) begin errors++; $display("FAIL single_shot_run_clear: got %0d pulses (%0d with frame_done) expected 1", n_rc, n_co); end
    checks++; if (n_fd != 1) begin errors++; $display("FAIL single_shot_frame_done: got %0d expected 1", n_fd); end
    loop_en = 1'b1; run = 1'b1; n_rc = 0; n_fd = 0;
    for (int i = 0; i < 20; i++) begin
      bit_of = (i < 4);
      tick();
      if (rc0 === 1'b1) n_rc++;
      if (fd0 === 1'b1) n_fd++;
    end
    bit_of = 1'b0;
    checks++; if (n_rc != 0) begin errors++; $display("FAIL loop_run_clear: got %0d expected 0", n_rc); end
    checks++; if (n_fd != 1) begin errors++; $display("FAIL loop_frame_done: got %0d expected 1", n_fd); end
  endtask

  task automatic test_max_clamp();
    bit seen = 0;
    max3 = 3'd7;
    bit_of = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pix1 !== 3'(m_pix[1]) || st1 !== exp_st(1)) begin errors++; $display("FAIL clamp_dut1_step%0d: got pix %0d state %b expected pix %0d state %b", i, pix1, st1, m_pix[1], exp_st(1)); end
      if (i == 3) begin
        checks++; if (pix0 !== 2'd0 || st0 !== ST_RESET) begin errors++; $display("FAIL clamp_dut0_wrap: got pix %0d state %b expected 0 %b", pix0, st0, ST_RESET); end
        checks++; if (pix1 !== 3'd4 || st1 !== ST_TRANSMIT) begin errors++; $display("FAIL clamp_dut1_last: got pix %0d state %b expected 4 %b", pix1, st1, ST_TRANSMIT); end
      end
    end
    checks++; if (pix1 !== 3'd0 || st1 !== ST_RESET) begin errors++; $display("FAIL clamp_dut1_wrap: got pix %0d state %b expected 0 %b", pix1, st1, ST_RESET); end
    checks++; if (st0 !== ST_RESET || pix0 !== 2'd0) begin errors++; $display("FAIL bit_of_ignored_in_gap: got pix %0d state %b expected 0 %b", pix0, st0, ST_RESET); end
    bit_of = 1'b0; max3 = 3'd3;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (fd0 === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL clamp_gap_timeout: got no frame_done expected one within 20 cycles"); end
    bit_of = 1'b1;
    tick(); tick();
    checks++; if (pix0 !== 2'd2) begin errors++; $display("FAIL lower_max_setup: got %0d expected 2", pix0); end
    max3 = 3'd1;
    tick();
    bit_of = 1'b0;
    checks++; if (pix0 !== 2'd0 || st0 !== ST_RESET) begin errors++; $display("FAIL lower_max_end: got pix %0d state %b expected 0 %b", pix0, st0, ST_RESET); end
    max3 = 3'd3;
  endtask

  task automatic test_pause();
    int n = 0;
    bit seen = 0, bad = 0;
    for (int i = 0; i < 4; i++) tick();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (st0 !== ST_RESET || fd0 !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL pause_hold: got state/frame_done change expected hold in gap"); end
    run = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(); n++;
      if (fd0 === 1'b1) seen = 1;
    end
    checks++; if (!seen || n != 4) begin errors++; $display("FAIL pause_resume_len: got %0d cycles (seen=%0d) expected 4", n, seen); end
  endtask

  task automatic test_init();
    int n = 0;
    bit seen = 0;
    bit_of = 1'b1;
    tick(); tick();
    checks++; if (pix0 !== 2'd2) begin errors++; $display("FAIL init_setup: got %0d expected 2", pix0); end
    init = 1'b1;
    tick();
    init = 1'b0; bit_of = 1'b0;
    checks++; if (pix0 !== 2'd0 || st0 !== ST_RESET) begin errors++; $display("FAIL init_priority: got pix %0d state %b expected 0 %b", pix0, st0, ST_RESET); end
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(); n++;
      if (fd0 === 1'b1) seen = 1;
    end
    checks++; if (!seen || n != RC) begin errors++; $display("FAIL init_full_gap: got %0d cycles (seen=%0d) expected %0d", n, seen, RC); end
    bit_of = 1'b1;
    tick();
    bit_of = 1'b0;
    checks++; if (pix0 !== 2'd1) begin errors++; $display("FAIL async_setup: got %0d expected 1", pix0); end
    #3 rst = 1'b1;
    #1;
    model_reset();
    checks++; if (pix0 !== 2'd0 || st0 !== ST_RESET) begin errors++; $display("FAIL async_reset: got pix %0d state %b expected 0 %b", pix0, st0, ST_RESET); end
    @(posedge clk7mhz); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit pfd0 = 0, prc0 = 0;
    for (int i = 0; i < 3000; i++) begin
      run     = ($urandom_range(0, 9) != 0);
      init    = ($urandom_range(0, 79) == 0);
      loop_en = ($urandom_range(0, 3) != 0);
      bit_of  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) max3 = 3'($urandom_range(0, 7));
      tick();
      checks++; if (st0 !== exp_st(0) || pix0 !== 2'(m_pix[0])) begin errors++; $display("FAIL rand_dut0_state_pix c%0d: got %b/%0d expected %b/%0d", i, st0, pix0, exp_st(0), m_pix[0]); end
      checks++; if (fd0 !== m_fd[0] || rc0 !== m_rc[0]) begin errors++; $display("FAIL rand_dut0_pulses c%0d: got fd %b rc %b expected fd %b rc %b", i, fd0, rc0, m_fd[0], m_rc[0]); end
      checks++; if (st1 !== exp_st(1) || pix1 !== 3'(m_pix[1])) begin errors++; $display("FAIL rand_dut1_state_pix c%0d: got %b/%0d expected %b/%0d", i, st1, pix1, exp_st(1), m_pix[1]); end
      checks++; if (fd1 !== m_fd[1] || rc1 !== m_rc[1]) begin errors++; $display("FAIL rand_dut1_pulses c%0d: got fd %b rc %b expected fd %b rc %b", i, fd1, rc1, m_fd[1], m_rc[1]); end
      checks++; if ((pfd0 && fd0 === 1'b1) || (prc0 && rc0 === 1'b1)) begin errors++; $display("FAIL rand_pulse_width c%0d: got two consecutive pulse cycles expected one", i); end
      pfd0 = (fd0 === 1'b1);
      prc0 = (rc0 === 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_first_gap();
    test_pixels();
    test_run_clear();
    test_max_clamp();
    test_pause();
    test_init();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
